div_operand_packer: RTL



---
 rtl/div_operand_packer_if.sv | 27 ++
 rtl/div_operand_packer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/div_operand_packer_if.sv
// Byte-stream / operand-pair handshake bundle for div_operand_packer.
// The slave modport is the packer's view; the master modport is the feeder/divider side.
interface div_operand_packer_if #(
    parameter int unsigned DIVIDEND_BYTES = 2,
    parameter int unsigned DIVISOR_BYTES  = 1
);
    logic                        i_valid;
    logic                        o_ready;
    logic [7:0]                  i_data;
    logic                        i_sof;
    logic                        o_valid;
    logic                        i_ready;
    logic [8*DIVIDEND_BYTES-1:0] o_dividend;
    logic [8*DIVISOR_BYTES-1:0]  o_divisor;
    logic                        o_div_by_zero;
    logic                        o_frame_err;

    modport master (
        output i_valid, i_data, i_sof, i_ready,
        input  o_ready, o_valid, o_dividend, o_divisor, o_div_by_zero, o_frame_err
    );

    modport slave (
        input  i_valid, i_data, i_sof, i_ready,
        output o_ready, o_valid, o_dividend, o_divisor, o_div_by_zero, o_frame_err
    );
endinterface

// File: rtl/div_operand_packer.sv
// Packs SOF-delimited byte frames into dividend/divisor words (MSB byte first) for the divider.
// Optional DIV_OPERAND_SKID_EN: separate collection and output registers for one frame per N cycles.
module div_operand_packer #(
    parameter int unsigned DIVIDEND_BYTES = 2,
    parameter int unsigned DIVISOR_BYTES  = 1
) (
    input logic                i_clk,
    input logic                i_reset_n,
    div_operand_packer_if.slave bus
);
    localparam int unsigned N  = DIVIDEND_BYTES + DIVISOR_BYTES;
    localparam int unsigned DW = 8 * DIVIDEND_BYTES;
    localparam int unsigned VW = 8 * DIVISOR_BYTES;
    localparam int unsigned FW = 8 * N;
    localparam int unsigned IW = $clog2(N);
`ifdef DIV_OPERAND_SKID_EN
    // A whole frame may have to wait here while the output register drains.
    localparam int unsigned CW = FW;
`else
    // The final byte goes straight from i_data to the output register.
    localparam int unsigned CW = FW - 8;
`endif

    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] coll_q, coll_d;
    logic [DW-1:0] dividend_q, dividend_d;
    logic [VW-1:0] divisor_q, divisor_d;
    logic          dbz_q, dbz_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ready_q, ready_d;

`ifdef DIV_OPERAND_SKID_EN
    logic pending_q, pending_d;
`else
    typedef enum logic [0:0] {StCollect, StHold} state_e;
    state_e state_q, state_d;
`endif

    logic          accept;
    logic          drain;
    logic          frame_done;
    logic          load_en;
    logic [FW-1:0] shifted;
    logic [FW-1:0] load_src;

    always_comb begin
        accept     = bus.i_valid && ready_q;
        drain      = valid_q && bus.i_ready;
`ifdef DIV_OPERAND_SKID_EN
        shifted    = {coll_q[FW-9:0], bus.i_data};
`else
        shifted    = {coll_q, bus.i_data};
`endif
        idx_d      = idx_q;
        coll_d     = coll_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        dbz_d      = dbz_q;
        valid_d    = valid_q;
        ferr_d     = 1'b0;
        frame_done = 1'b0;
        load_en    = 1'b0;
        load_src   = shifted;
`ifdef DIV_OPERAND_SKID_EN
        pending_d  = pending_q;
`else
        state_d    = state_q;
`endif

        if (accept) begin
            if (idx_q == '0 && !bus.i_sof) begin
                ferr_d = 1'b1;
            end else if (idx_q != '0 && bus.i_sof) begin
                // Resync: the SOF byte starts a fresh frame at index 0.
                ferr_d = 1'b1;
                coll_d = CW'(bus.i_data);
                idx_d  = IW'(1);
            end else if (idx_q == IW'(N - 1)) begin
                frame_done = 1'b1;
                coll_d     = shifted[CW-1:0];
                idx_d      = '0;
            end else begin
                coll_d = shifted[CW-1:0];
                idx_d  = idx_q + 1'b1;
            end
        end

        if (drain) begin
            valid_d = 1'b0;
        end

`ifdef DIV_OPERAND_SKID_EN
        if (frame_done) begin
            if (!valid_q || drain) begin
                load_en = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end else if (pending_q && drain) begin
            load_en   = 1'b1;
            load_src  = coll_q;
            pending_d = 1'b0;
        end
        ready_d = !pending_d;
`else
        if (frame_done) begin
            load_en = 1'b1;
            state_d = StHold;
        end else if (state_q == StHold && drain) begin
            state_d = StCollect;
        end
        ready_d = (state_d == StCollect);
`endif

        if (load_en) begin
            dividend_d = load_src[FW-1 -: DW];
            divisor_d  = load_src[VW-1:0];
            dbz_d      = (load_src[VW-1:0] == '0);
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            idx_q      <= '0;
            coll_q     <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            dbz_q      <= 1'b0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ready_q    <= 1'b0;
`ifdef DIV_OPERAND_SKID_EN
            pending_q  <= 1'b0;
`else
            state_q    <= StCollect;
`endif
        end else begin
            idx_q      <= idx_d;
            coll_q     <= coll_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            dbz_q      <= dbz_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            ready_q    <= ready_d;
`ifdef DIV_OPERAND_SKID_EN
            pending_q  <= pending_d;
`else
            state_q    <= state_d;
`endif
        end
    end

    assign bus.o_ready       = ready_q;
    assign bus.o_valid       = valid_q;
    assign bus.o_dividend    = dividend_q;
    assign bus.o_divisor     = divisor_q;
    assign bus.o_div_by_zero = dbz_q;
    assign bus.o_frame_err   = ferr_q;
endmodule
